// File: rtl/arrow_track_sequencer_if.sv
// Song-memory fetch bus between the arrow track sequencer (master) and the song ROM/RAM (slave).
// Handshake: master raises song_req with song_addr stable; slave pulses song_ack for one cycle with
// song_data valid in that cycle; master drops song_req on the edge that samples song_ack.
interface arrow_track_sequencer_if #(
  parameter int SONG_ADDR_W = 10,
  parameter int LANE_W      = 3
);
  logic                   song_req;
  logic [SONG_ADDR_W-1:0] song_addr;
  logic                   song_ack;
  logic [LANE_W-1:0]      song_data;

  modport master (output song_req, song_addr, input song_ack, song_data);
  modport slave  (input song_req, song_addr, output song_ack, song_data);
endinterface

// File: rtl/arrow_track_sequencer.sv
// Scrolls a track of lane codes for the VGA arrow renderer: one note fetched per scroll step,
// shifted in every FRAMES_PER_STEP frames, then drained with empty codes until song_done.
module arrow_track_sequencer #(
  parameter int NUM_STATES      = 26,
  parameter int LANE_W          = 3,
  parameter int FRAMES_PER_STEP = 8,
  parameter int SONG_ADDR_W     = 10,
  parameter int SONG_LEN        = 1000,
  localparam int FC_W           = $clog2(FRAMES_PER_STEP)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_pause,
  input  logic                         i_frame_tick,
  arrow_track_sequencer_if.master      song,
  output logic [NUM_STATES*LANE_W-1:0] o_arrow_array,
  output logic                         o_step_pulse,
  output logic                         o_song_done,
  output logic                         o_overrun,
  output logic [2:0]                   o_state,
  output logic [FC_W-1:0]              o_frame_cnt
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One extra address bit so SONG_LEN == 2**SONG_ADDR_W can still be compared against.
  localparam int AW = SONG_ADDR_W + 1;
  localparam logic [AW-1:0] LEN_A = AW'(SONG_LEN);
  localparam int DW = $clog2(NUM_STATES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NUM_STATES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

  logic [2:0]                   r_state;
  logic [NUM_STATES*LANE_W-1:0] r_arr;
  logic [AW-1:0]                r_addr;
  logic [LANE_W-1:0]            r_note;
  logic [FC_W-1:0]              r_frame_cnt;
  logic                         r_step_pending;
  logic [DW-1:0]                r_drain_cnt;
  logic                         r_overrun;

  logic              w_counting;
  logic              w_tick;
  logic              w_wrap;
  logic              w_consume;
  logic              w_has_note;
  logic [LANE_W-1:0] w_note_in;

  assign w_counting = (r_state == S_WAIT) || (r_state == S_FETCH) || (r_state == S_SHIFT);
  assign w_tick     = w_counting && i_frame_tick && !i_pause;
  assign w_wrap     = w_tick && (r_frame_cnt == FC_LAST);
  assign w_consume  = (r_state == S_WAIT) && r_step_pending && !i_pause;
  assign w_has_note = (r_addr < LEN_A);
  // Codes 101 and 111 are not valid lanes; they render as empty.
  assign w_note_in  = ((song.song_data == LANE_W'(5)) || (song.song_data == LANE_W'(7)))
                      ? '0 : song.song_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_arr          <= '0;
      r_addr         <= '0;
      r_note         <= '0;
      r_frame_cnt    <= '0;
      r_step_pending <= 1'b0;
      r_drain_cnt    <= '0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_tick) r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + 1'b1;

      // A step that is consumed in the same cycle a new one falls due is not an overrun.
      if (w_wrap) begin
        r_step_pending <= 1'b1;
        if (r_step_pending && !w_consume) r_overrun <= 1'b1;
      end else if (w_consume) begin
        r_step_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_arr          <= '0;
            r_addr         <= '0;
            r_frame_cnt    <= '0;
            r_drain_cnt    <= '0;
            r_overrun      <= 1'b0;
            r_step_pending <= 1'b0;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_consume) begin
            if (w_has_note) begin
              r_state <= S_FETCH;
            end else begin
              r_note  <= '0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_FETCH: begin
          if (song.song_ack) begin
            r_note  <= w_note_in;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_arr <= {r_arr[(NUM_STATES-1)*LANE_W-1:0], r_note};
          if (w_has_note) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
            r_state     <= (r_drain_cnt == DRAIN_LAST) ? S_DONE : S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign song.song_req  = (r_state == S_FETCH);
  assign song.song_addr = r_addr[SONG_ADDR_W-1:0];
  assign o_arrow_array  = r_arr;
  assign o_step_pulse   = (r_state == S_SHIFT);
  assign o_song_done    = (r_state == S_DONE);
  assign o_overrun      = r_overrun;
  assign o_state        = r_state;
  assign o_frame_cnt    = r_frame_cnt;
endmodule
